// File: rtl/buffer_fill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsc_pkg
// Description : Shared types and constants for the buffer fill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dsc_pkg;

    localparam int DEFAULT_NUM_BUF = 4;

    typedef logic [0:0] state_t;

    localparam state_t ST_FILL = 1'b0;
    localparam state_t ST_HOLD = 1'b1;

endpackage : dsc_pkg
`default_nettype wire

// File: rtl/buffer_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : buffer_fill_ctrl_if
// Description : Sample stream, lane write enables and group handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface buffer_fill_ctrl_if
    import dsc_pkg::*;
#(
    parameter int NUM_BUF = DEFAULT_NUM_BUF
);
    localparam int CNT_W = $clog2(NUM_BUF + 1);

    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [NUM_BUF-1:0] buf_we;
    logic               grp_valid;
    logic               grp_ready;
    logic [CNT_W-1:0]   grp_count;
    logic               grp_last;

    // Controller side
    modport slave (
        input  in_valid, in_last, grp_ready,
        output in_ready, buf_we, grp_valid, grp_count, grp_last
    );

    // Upstream source / downstream engine side
    modport master (
        output in_valid, in_last, grp_ready,
        input  in_ready, buf_we, grp_valid, grp_count, grp_last
    );

endinterface : buffer_fill_ctrl_if
`default_nettype wire

// File: rtl/buffer_fill_ctrl_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dec
// Description : Index to one-hot decoder with a global enable.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec #(
    parameter int NUM_BUF = 4,
    parameter int IDX_W   = $clog2(NUM_BUF)
) (
    input  wire logic [IDX_W-1:0]   idx_i,
    input  wire logic               en_i,
    output logic      [NUM_BUF-1:0] dec_o
);

    for (genvar i = 0; i < NUM_BUF; i++) begin : g_lane
        assign dec_o[i] = en_i & (idx_i == IDX_W'(i));
    end

endmodule : onehot_dec
`default_nettype wire

// File: rtl/buffer_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : buffer_fill_ctrl
// Description : Steers a serial sample stream into NUM_BUF lanes and presents
//               each filled group downstream with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_fill_ctrl
    import dsc_pkg::*;
#(
    parameter int NUM_BUF = DEFAULT_NUM_BUF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          clr_i,
    buffer_fill_ctrl_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_BUF);
    localparam int CNT_W = $clog2(NUM_BUF + 1);

    state_t             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic               in_ready_q,  in_ready_d;
    logic               grp_valid_q, grp_valid_d;
    logic [CNT_W-1:0]   grp_count_q, grp_count_d;
    logic               grp_last_q,  grp_last_d;

    logic               w_acc;
    logic               w_close;

    // clr suppresses the write even though in_ready is still high that cycle
    assign w_acc   = bus.in_valid & in_ready_q & ~clr_i;
    assign w_close = (idx_q == IDX_W'(NUM_BUF - 1)) | bus.in_last;

    onehot_dec #(
        .NUM_BUF (NUM_BUF),
        .IDX_W   (IDX_W)
    ) u_dec (
        .idx_i (idx_q),
        .en_i  (w_acc),
        .dec_o (bus.buf_we)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_ready_d  = in_ready_q;
        grp_valid_d = grp_valid_q;
        grp_count_d = grp_count_q;
        grp_last_d  = grp_last_q;

        if (clr_i) begin
            state_d     = ST_FILL;
            idx_d       = '0;
            in_ready_d  = 1'b1;
            grp_valid_d = 1'b0;
            grp_count_d = '0;
            grp_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    // Also raises in_ready on the first edge out of reset
                    in_ready_d = 1'b1;
                    if (w_acc) begin
                        if (w_close) begin
                            state_d     = ST_HOLD;
                            idx_d       = '0;
                            in_ready_d  = 1'b0;
                            grp_valid_d = 1'b1;
                            grp_count_d = CNT_W'(idx_q) + CNT_W'(1);
                            grp_last_d  = bus.in_last;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.grp_ready) begin
                        state_d     = ST_FILL;
                        grp_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_FILL;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            grp_valid_q <= 1'b0;
            grp_count_q <= '0;
            grp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            grp_valid_q <= grp_valid_d;
            grp_count_q <= grp_count_d;
            grp_last_q  <= grp_last_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.grp_valid = grp_valid_q;
    assign bus.grp_count = grp_count_q;
    assign bus.grp_last  = grp_last_q;

endmodule : buffer_fill_ctrl
`default_nettype wire

// File: tb/tb_buffer_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_fill_ctrl
// Description : Directed and randomized self-checking bench, NUM_BUF = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_fill_ctrl;

    localparam int NUM_BUF = 4;

    logic clk;
    logic rst_n;
    logic clr;
    int   checks;
    int   errors;

    buffer_fill_ctrl_if #(.NUM_BUF(NUM_BUF)) bus ();

    buffer_fill_ctrl #(.NUM_BUF(NUM_BUF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled there too
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_clr();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        clr          = 1'b1;
        step();
        clr          = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.grp_ready = 1'b0;
        repeat (2) step();
        checks++;
        if ({bus.in_ready, bus.grp_valid, bus.grp_count, bus.grp_last, bus.buf_we} !== 10'b0) begin
            errors++;
            $display("FAIL reset_vals: got rdy=%b gv=%b cnt=%0d last=%b we=%b, want all 0",
                     bus.in_ready, bus.grp_valid, bus.grp_count, bus.grp_last, bus.buf_we);
        end
        bus.in_valid  = 1'b1;
        bus.grp_ready = 1'b1;
        rst_n         = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready_rise: got %b want 1", bus.in_ready);
        end
        for (int i = 0; i < NUM_BUF; i++) begin
            logic [3:0] exp_we;
            exp_we = 4'b0001 << i;
            if (i > 0) step();
            checks++;
            if (bus.buf_we !== exp_we) begin
                errors++;
                $display("FAIL fill_we lane%0d: got %b want %b", i, bus.buf_we, exp_we);
            end
        end
        step();
        checks++;
        if (bus.grp_valid !== 1'b1 || bus.grp_count !== 3'd4 || bus.grp_last !== 1'b0 ||
            bus.in_ready !== 1'b0 || bus.buf_we !== 4'b0000) begin
            errors++;
            $display("FAIL full_group: got gv=%b cnt=%0d last=%b rdy=%b we=%b want 1 4 0 0 0000",
                     bus.grp_valid, bus.grp_count, bus.grp_last, bus.in_ready, bus.buf_we);
        end
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.grp_valid !== 1'b0) begin
            errors++;
            $display("FAIL group_consumed: got rdy=%b gv=%b want 1 0", bus.in_ready, bus.grp_valid);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_last();
        do_clr();
        bus.grp_ready = 1'b1;
        bus.in_valid  = 1'b1;
        #1;
        checks++;
        if (bus.buf_we !== 4'b0001) begin
            errors++;
            $display("FAIL last_we0: got %b want 0001", bus.buf_we);
        end
        step();
        checks++;
        if (bus.buf_we !== 4'b0010) begin
            errors++;
            $display("FAIL last_we1: got %b want 0010", bus.buf_we);
        end
        step();
        bus.in_last = 1'b1;
        #1;
        checks++;
        if (bus.buf_we !== 4'b0100) begin
            errors++;
            $display("FAIL last_we2: got %b want 0100", bus.buf_we);
        end
        step();
        bus.in_last = 1'b0;
        checks++;
        if (bus.grp_valid !== 1'b1 || bus.grp_count !== 3'd3 || bus.grp_last !== 1'b1) begin
            errors++;
            $display("FAIL last_group: got gv=%b cnt=%0d last=%b want 1 3 1",
                     bus.grp_valid, bus.grp_count, bus.grp_last);
        end
        step();
        checks++;
        if (bus.buf_we !== 4'b0001) begin
            errors++;
            $display("FAIL last_restart: got %b want 0001", bus.buf_we);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_hold_stall();
        do_clr();
        bus.grp_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (NUM_BUF) step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.grp_valid !== 1'b1 || bus.grp_count !== 3'd4 || bus.in_ready !== 1'b0 ||
                bus.buf_we !== 4'b0000) begin
                errors++;
                $display("FAIL hold_stable c%0d: got gv=%b cnt=%0d rdy=%b we=%b want 1 4 0 0000",
                         i, bus.grp_valid, bus.grp_count, bus.in_ready, bus.buf_we);
            end
            step();
        end
        bus.grp_ready = 1'b1;
        step();
        checks++;
        if (bus.grp_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got gv=%b rdy=%b want 0 1", bus.grp_valid, bus.in_ready);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_clr();
        do_clr();
        bus.grp_ready = 1'b1;
        bus.in_valid  = 1'b1;
        repeat (2) step();
        checks++;
        if (bus.buf_we !== 4'b0100) begin
            errors++;
            $display("FAIL clr_pre: got %b want 0100", bus.buf_we);
        end
        clr = 1'b1;
        #1;
        checks++;
        if (bus.buf_we !== 4'b0000) begin
            errors++;
            $display("FAIL clr_we_block: got %b want 0000", bus.buf_we);
        end
        step();
        clr = 1'b0;
        #1;
        checks++;
        if (bus.grp_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.buf_we !== 4'b0001) begin
            errors++;
            $display("FAIL clr_after: got gv=%b rdy=%b we=%b want 0 1 0001",
                     bus.grp_valid, bus.in_ready, bus.buf_we);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_rst_mid();
        do_clr();
        bus.grp_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_last   = 1'b1;
        step();
        bus.in_last = 1'b0;
        checks++;
        if (bus.grp_valid !== 1'b1 || bus.grp_count !== 3'd1 || bus.grp_last !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_hold: got gv=%b cnt=%0d last=%b want 1 1 1",
                     bus.grp_valid, bus.grp_count, bus.grp_last);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.grp_valid !== 1'b0 || bus.grp_count !== 3'd0 || bus.grp_last !== 1'b0 ||
            bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got gv=%b cnt=%0d last=%b rdy=%b want 0 0 0 0",
                     bus.grp_valid, bus.grp_count, bus.grp_last, bus.in_ready);
        end
        step();
        rst_n         = 1'b1;
        bus.grp_ready = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.buf_we !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_restart: got rdy=%b we=%b want 1 0001", bus.in_ready, bus.buf_we);
        end
        step();
        checks++;
        if (bus.buf_we !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid_lane1: got %b want 0010", bus.buf_we);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_random();
        int         lane;
        int         acc_total;
        int         grp_sum;
        int         exp_cnt;
        logic [3:0] exp_we;
        logic       acc;
        lane      = 0;
        acc_total = 0;
        grp_sum   = 0;
        exp_cnt   = 0;
        do_clr();
        for (int c = 0; c < 10000; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_last   = ($urandom_range(0, 4) == 0);
            bus.grp_ready = ($urandom_range(0, 1) == 1);
            #1;
            acc    = bus.in_valid & bus.in_ready;
            exp_we = acc ? (4'b0001 << lane) : 4'b0000;
            checks++;
            if (bus.buf_we !== exp_we || $countones(bus.buf_we) > 1) begin
                errors++;
                $display("FAIL rand_we c%0d: got %b want %b", c, bus.buf_we, exp_we);
            end
            if (bus.grp_valid && bus.grp_ready) begin
                checks++;
                if (int'(bus.grp_count) !== exp_cnt) begin
                    errors++;
                    $display("FAIL rand_cnt c%0d: got %0d want %0d", c, bus.grp_count, exp_cnt);
                end
                grp_sum += int'(bus.grp_count);
            end
            if (acc) begin
                acc_total++;
                if (lane == NUM_BUF - 1 || bus.in_last) begin
                    exp_cnt = lane + 1;
                    lane    = 0;
                end else begin
                    lane++;
                end
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.grp_ready = 1'b1;
        #1;
        if (bus.grp_valid) grp_sum += int'(bus.grp_count);
        step();
        checks++;
        if (acc_total !== grp_sum + lane) begin
            errors++;
            $display("FAIL rand_total: accepted %0d, group sum %0d + pending %0d",
                     acc_total, grp_sum, lane);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_last();
        test_hold_stall();
        test_clr();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_buffer_fill_ctrl
`default_nettype wire
